// File: rtl/dtw_dispatch.sv
// dtw_dispatch: shares one query stream across N_CORES dtw_core instances.
//   Dispatch side: takes one query record (qid + SQG_SIZE samples) from the
//   upstream FWFT FIFO. It picks an idle core round-robin, pulses that core's
//   start, then streams the record into the core's input FIFO.
//   Collect side: moves each core's 3-word result record (qid, position,
//   minval) into the shared sink FIFO, round-robin across cores. Records from
//   different cores are never interleaved.
// Optional feature macro: DTW_DISPATCH_STATS_EN adds the stat_dispatched and
//   stat_collected counters.
module dtw_dispatch #(
    parameter int N_CORES  = 4,
    parameter int SQG_SIZE = 250
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic                   idle,
    output logic                   src_fifo_rden,
    input  logic                   src_fifo_empty,
    input  logic [31:0]            src_fifo_data,
    output logic [N_CORES-1:0]     core_start,
    output logic [N_CORES-1:0]     core_wr_en,
    input  logic [N_CORES-1:0]     core_full,
    output logic [31:0]            core_wr_data,
    output logic [N_CORES-1:0]     core_rd_en,
    input  logic [N_CORES-1:0]     core_empty,
    input  logic [32*N_CORES-1:0]  core_rd_data,
    output logic                   sink_fifo_wren,
    input  logic                   sink_fifo_full,
    output logic [31:0]            sink_fifo_data
`ifdef DTW_DISPATCH_STATS_EN
    ,
    output logic [31:0]            stat_dispatched,
    output logic [31:0]            stat_collected
`endif
);

    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int CW = $clog2(SQG_SIZE + 1);
    localparam logic [CW-1:0]      WCNT_LAST   = CW'(SQG_SIZE);
    localparam logic [N_CORES-1:0] ONE_HOT_LSB = N_CORES'(1);
    localparam logic [PW-1:0]      PTR_LAST    = PW'(N_CORES - 1);

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_PICK   = 2'd1,
        D_START  = 2'd2,
        D_STREAM = 2'd3
    } d_state_t;

    typedef enum logic {
        C_SCAN = 1'b0,
        C_XFER = 1'b1
    } c_state_t;

    d_state_t d_state_r, d_next_s;
    c_state_t c_state_r, c_next_s;

    logic [N_CORES-1:0] busy_r;
    logic [N_CORES-1:0] busy_nxt_s;
    logic [N_CORES-1:0] busy_set_s;
    logic [N_CORES-1:0] busy_clr_s;
    logic [N_CORES-1:0] free_s;
    logic [N_CORES-1:0] scan_req_s;
    logic [PW-1:0]      dptr_r, cptr_r;
    logic [PW-1:0]      dsel_r, csel_r;
    logic [PW-1:0]      dpick_s, cpick_s;
    logic [CW-1:0]      wcnt_r;
    logic [1:0]         rcnt_r;
    logic [N_CORES-1:0] core_start_r;
    logic               idle_r;
    logic               d_xfer_s, d_last_s;
    logic               c_xfer_s, c_last_s;

    // Decode a core index into a one-hot core vector.
    function automatic logic [N_CORES-1:0] onehot(input logic [PW-1:0] idx);
        return ONE_HOT_LSB << idx;
    endfunction

    // Advance a round-robin pointer, wrapping at N_CORES.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? PW'(0) : p + PW'(1);
    endfunction

    // First requesting index at or after ptr, wrapping; returns ptr if none.
    function automatic logic [PW-1:0] rr_pick(input logic [N_CORES-1:0] req,
                                              input logic [PW-1:0]      ptr);
        logic [PW-1:0] pick;
        logic [PW-1:0] idx_v;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            idx   = (int'(ptr) + i >= N_CORES) ? int'(ptr) + i - N_CORES : int'(ptr) + i;
            idx_v = PW'(idx);
            pick  = (!found && req[idx_v]) ? idx_v : pick;
            found = found | req[idx_v];
        end
        return pick;
    endfunction

    // Next-state, transfer qualifiers and busy update for both FSMs.
    always_comb begin
        d_next_s   = d_state_r;
        c_next_s   = c_state_r;
        free_s     = ~busy_r;
        scan_req_s = busy_r & ~core_empty;
        dpick_s    = rr_pick(free_s, dptr_r);
        cpick_s    = rr_pick(scan_req_s, cptr_r);
        d_xfer_s   = 1'b0;
        d_last_s   = 1'b0;
        c_xfer_s   = 1'b0;
        c_last_s   = 1'b0;
        busy_set_s = '0;
        busy_clr_s = '0;

        case (d_state_r)
            D_IDLE: begin
                if (enable && !src_fifo_empty && (free_s != '0)) begin
                    d_next_s = D_PICK;
                end else begin
                    d_next_s = D_IDLE;
                end
            end
            D_PICK: begin
                d_next_s = D_START;
            end
            D_START: begin
                busy_set_s = onehot(dsel_r);
                d_next_s   = D_STREAM;
            end
            D_STREAM: begin
                d_xfer_s = !src_fifo_empty && !core_full[dsel_r];
                d_last_s = d_xfer_s && (wcnt_r == WCNT_LAST);
                if (d_last_s) begin
                    d_next_s = D_IDLE;
                end else begin
                    d_next_s = D_STREAM;
                end
            end
            default: begin
                d_next_s = D_IDLE;
            end
        endcase

        case (c_state_r)
            C_SCAN: begin
                if (scan_req_s != '0) begin
                    c_next_s = C_XFER;
                end else begin
                    c_next_s = C_SCAN;
                end
            end
            C_XFER: begin
                c_xfer_s = !core_empty[csel_r] && !sink_fifo_full;
                c_last_s = c_xfer_s && (rcnt_r == 2'd2);
                if (c_last_s) begin
                    busy_clr_s = onehot(csel_r);
                    c_next_s   = C_SCAN;
                end else begin
                    c_next_s   = C_XFER;
                end
            end
            default: begin
                c_next_s = C_SCAN;
            end
        endcase

        // A set needs !busy and a clear needs busy, so they never hit one bit together.
        busy_nxt_s = (busy_r | busy_set_s) & ~busy_clr_s;
    end

    assign src_fifo_rden  = d_xfer_s;
    assign core_wr_en     = d_xfer_s ? onehot(dsel_r) : '0;
    assign core_wr_data   = src_fifo_data;
    assign core_rd_en     = c_xfer_s ? onehot(csel_r) : '0;
    assign sink_fifo_wren = c_xfer_s;
    assign sink_fifo_data = core_rd_data[{csel_r, 5'b00000} +: 32];
    assign core_start     = core_start_r;
    assign idle           = idle_r;

    // FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_state_r <= D_IDLE;
            c_state_r <= C_SCAN;
        end else begin
            d_state_r <= d_next_s;
            c_state_r <= c_next_s;
        end
    end

    // Dispatch datapath: selected core, start pulse, word counter, RR pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsel_r       <= '0;
            core_start_r <= '0;
            wcnt_r       <= '0;
            dptr_r       <= '0;
        end else begin
            if (d_state_r == D_PICK) begin
                dsel_r       <= dpick_s;
                core_start_r <= onehot(dpick_s);
            end else begin
                dsel_r       <= dsel_r;
                core_start_r <= '0;
            end
            if (d_state_r == D_START) begin
                wcnt_r <= '0;
            end else if (d_xfer_s) begin
                wcnt_r <= wcnt_r + CW'(1);
            end else begin
                wcnt_r <= wcnt_r;
            end
            if (d_last_s) begin
                dptr_r <= ptr_inc(dsel_r);
            end else begin
                dptr_r <= dptr_r;
            end
        end
    end

    // Collect datapath: selected core, result word counter, RR pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csel_r <= '0;
            rcnt_r <= 2'd0;
            cptr_r <= '0;
        end else begin
            if ((c_state_r == C_SCAN) && (scan_req_s != '0)) begin
                csel_r <= cpick_s;
                rcnt_r <= 2'd0;
            end else if (c_xfer_s) begin
                csel_r <= csel_r;
                rcnt_r <= c_last_s ? 2'd0 : rcnt_r + 2'd1;
            end else begin
                csel_r <= csel_r;
                rcnt_r <= rcnt_r;
            end
            if (c_last_s) begin
                cptr_r <= ptr_inc(csel_r);
            end else begin
                cptr_r <= cptr_r;
            end
        end
    end

    // Per-core busy flags and the registered idle indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
            idle_r <= 1'b1;
        end else begin
            busy_r <= busy_nxt_s;
            idle_r <= (busy_nxt_s == '0) && (d_next_s == D_IDLE);
        end
    end

`ifdef DTW_DISPATCH_STATS_EN
    logic [31:0] stat_dispatched_r;
    logic [31:0] stat_collected_r;

    // Free-running counts of started queries and completed result records.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_dispatched_r <= 32'd0;
            stat_collected_r  <= 32'd0;
        end else begin
            stat_dispatched_r <= (core_start_r != '0) ? stat_dispatched_r + 32'd1 : stat_dispatched_r;
            stat_collected_r  <= c_last_s ? stat_collected_r + 32'd1 : stat_collected_r;
        end
    end

    assign stat_dispatched = stat_dispatched_r;
    assign stat_collected  = stat_collected_r;
`endif

endmodule

// File: tb/tb_dtw_dispatch.sv
// Testbench for dtw_dispatch: random source/core/sink behaviour checked
// against a queue-based model of records, busy cores and round-robin choice.
module tb_dtw_dispatch;

    localparam int N  = 4;
    localparam int SQ = 250;
    localparam int RL = SQ + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              idle;
    logic              src_fifo_rden;
    logic              src_fifo_empty = 1'b1;
    logic [31:0]       src_fifo_data = 32'd0;
    logic [N-1:0]      core_start;
    logic [N-1:0]      core_wr_en;
    logic [N-1:0]      core_full = '0;
    logic [31:0]       core_wr_data;
    logic [N-1:0]      core_rd_en;
    logic [N-1:0]      core_empty = '1;
    logic [32*N-1:0]   core_rd_data = '0;
    logic              sink_fifo_wren;
    logic              sink_fifo_full = 1'b0;
    logic [31:0]       sink_fifo_data;
`ifdef DTW_DISPATCH_STATS_EN
    logic [31:0]       stat_dispatched;
    logic [31:0]       stat_collected;
`endif

    dtw_dispatch #(.N_CORES(N), .SQG_SIZE(SQ)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .idle(idle),
        .src_fifo_rden(src_fifo_rden), .src_fifo_empty(src_fifo_empty),
        .src_fifo_data(src_fifo_data), .core_start(core_start),
        .core_wr_en(core_wr_en), .core_full(core_full), .core_wr_data(core_wr_data),
        .core_rd_en(core_rd_en), .core_empty(core_empty), .core_rd_data(core_rd_data),
        .sink_fifo_wren(sink_fifo_wren), .sink_fifo_full(sink_fifo_full),
        .sink_fifo_data(sink_fifo_data)
`ifdef DTW_DISPATCH_STATS_EN
        , .stat_dispatched(stat_dispatched), .stat_collected(stat_collected)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model state
    logic [31:0] srcq[$];
    logic [31:0] next_qid = 32'h0000_0100;
    logic [31:0] res_w [N][3];
    logic [31:0] core_qid [N];
    bit          res_valid [N];
    int          res_rd [N];
    int          ready_at [N];
    int          rx_cnt [N];
    logic [N-1:0] busy_m, busy_prev, busy_pick;
    logic [N-1:0] hold_res, force_full;
    int          dptr_m, cur_core, popped;
    int          col_core, col_cnt;
    int          col_order[$];
    int          start_order[$];
    int          n_starts, n_collected;
    bit          rnd_src, rnd_full, rnd_res, rnd_sink, drop_at100;
    int          en_low = 0;
    int          cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int low_bit(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    // first free core at or after p, wrapping
    function automatic int rr_free(input logic [N-1:0] b, input int p);
        for (int i = 0; i < N; i++) if (!b[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic clear_model();
        srcq.delete();
        col_order.delete();
        start_order.delete();
        busy_m = '0; busy_prev = '0; busy_pick = '0;
        dptr_m = 0; cur_core = -1; popped = 0;
        col_core = 0; col_cnt = 0; n_starts = 0; n_collected = 0;
        for (int k = 0; k < N; k++) begin
            res_valid[k] = 1'b0; res_rd[k] = 0; ready_at[k] = 0; rx_cnt[k] = 0;
        end
    endtask

    task automatic push_record();
        srcq.push_back(next_qid);
        for (int i = 0; i < SQ; i++) srcq.push_back($urandom);
        next_qid = next_qid + 32'd1;
    endtask

    // One clock: drive inputs after the falling edge, then sample and update model.
    task automatic step();
        int k;
        int j;
        @(negedge clk);
        cyc++;
        busy_pick = busy_prev;
        busy_prev = busy_m;
        if (drop_at100 && cur_core >= 0 && rx_cnt[cur_core] == 100) begin
            enable = 1'b0;
            drop_at100 = 1'b0;
        end
        en_low = enable ? 0 : en_low + 1;
        src_fifo_empty = (srcq.size() == 0) || (rnd_src && $urandom_range(3) == 0);
        src_fifo_data  = (srcq.size() != 0) ? srcq[0] : 32'hDEAD_BEEF;
        for (int c = 0; c < N; c++) begin
            core_full[c]  = force_full[c] || (rnd_full && $urandom_range(4) == 0);
            core_empty[c] = !(res_valid[c] && !hold_res[c] && cyc >= ready_at[c])
                            || (rnd_res && $urandom_range(3) == 0);
            core_rd_data[32*c +: 32] = res_valid[c] ? res_w[c][res_rd[c]] : 32'd0;
        end
        sink_fifo_full = rnd_sink && ($urandom_range(2) == 0);
        #2;
        // dispatch side
        if (core_start != '0) begin
            k = low_bit(core_start);
            check_eq("start_onehot", 32'($countones(core_start)), 32'd1);
            check_eq("start_core", 32'(k), 32'(rr_free(busy_pick, dptr_m)));
            check_eq("start_while_disabled", 32'(en_low >= 3), 32'd0);
            check_eq("start_prev_done", 32'(cur_core < 0 || rx_cnt[cur_core] == RL), 32'd1);
            busy_m[k] = 1'b1;
            dptr_m = (k + 1) % N;
            cur_core = k;
            rx_cnt[k] = 0;
            start_order.push_back(k);
            n_starts++;
        end
        if (src_fifo_rden) begin
            check_eq("rden_gate", 32'({src_fifo_empty, (cur_core >= 0) ? core_full[cur_core] : 1'b1}), 32'd0);
            check_eq("wr_en_core", 32'(core_wr_en), (cur_core >= 0) ? 32'(1 << cur_core) : 32'd0);
            if (srcq.size() != 0 && cur_core >= 0) begin
                check_eq("wr_data", core_wr_data, srcq[0]);
                check_eq("record_align", 32'(rx_cnt[cur_core]), 32'(popped % RL));
                if (rx_cnt[cur_core] == 0) core_qid[cur_core] = srcq[0];
                void'(srcq.pop_front());
                popped++;
                rx_cnt[cur_core]++;
                if (rx_cnt[cur_core] == RL) begin
                    res_w[cur_core][0] = core_qid[cur_core];
                    res_w[cur_core][1] = $urandom_range(SQ);
                    res_w[cur_core][2] = $urandom;
                    res_valid[cur_core] = 1'b1;
                    res_rd[cur_core] = 0;
                    ready_at[cur_core] = cyc + int'($urandom_range(15, 1));
                end
            end
        end else begin
            check_eq("wr_en_idle", 32'(core_wr_en), 32'd0);
        end
        // collect side
        if (sink_fifo_wren || core_rd_en != '0) begin
            j = (col_cnt > 0) ? col_core : low_bit(core_rd_en);
            check_eq("rd_en_sel", 32'(core_rd_en), sink_fifo_wren ? 32'(1 << j) : 32'd0);
            check_eq("rd_gate", 32'({sink_fifo_full, core_empty[j]}), 32'd0);
            check_eq("collect_busy", 32'(busy_m[j]), 32'd1);
            if (res_valid[j] && res_rd[j] < 3) begin
                check_eq("sink_data", sink_fifo_data, res_w[j][res_rd[j]]);
                res_rd[j]++;
            end
            col_core = j;
            col_cnt++;
            if (col_cnt == 3) begin
                busy_m[j] = 1'b0;
                res_valid[j] = 1'b0;
                col_cnt = 0;
                col_order.push_back(j);
                n_collected++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int ff_left, ff_cycles, ff_leak, saved;
        bit ff_done;
        hold_res = '0; force_full = '0;
        rnd_src = 0; rnd_full = 0; rnd_res = 0; rnd_sink = 0; drop_at100 = 0;
        clear_model();

        // reset state
        repeat (3) step();
        check_eq("reset_idle", 32'(idle), 32'd1);
        check_eq("reset_strobes", 32'({core_start, core_wr_en, core_rd_en, src_fifo_rden, sink_fifo_wren}), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();
        check_eq("post_reset_idle", 32'(idle), 32'd1);

        // four records to four idle cores in order; core 2 stalls for 10 cycles
        hold_res = '1;
        for (int r = 0; r < 4; r++) push_record();
        enable = 1'b1;
        ok = 0; ff_left = 0; ff_cycles = 0; ff_leak = 0; ff_done = 0;
        for (int i = 0; i < 3000; i++) begin
            if (ff_left == 0 && !ff_done && cur_core == 2 && rx_cnt[2] == 50) begin
                ff_left = 10; ff_done = 1;
            end
            force_full = '0;
            force_full[2] = (ff_left > 0);
            step();
            if (ff_left > 0) begin
                if (src_fifo_rden) ff_leak++;
                ff_left--; ff_cycles++;
            end
            if (n_starts == 4 && rx_cnt[3] == RL) begin ok = 1; break; end
        end
        force_full = '0;
        check_eq("t1_done", 32'(ok), 32'd1);
        for (int i = 0; i < 4; i++)
            check_eq("t1_start_order", (start_order.size() > i) ? 32'(start_order[i]) : 32'hFFFF_FFFF, 32'(i));
        for (int i = 0; i < 4; i++) check_eq("t1_words", 32'(rx_cnt[i]), 32'(RL));
        check_eq("t2_stall_cycles", 32'(ff_cycles), 32'd10);
        check_eq("t2_rden_in_stall", 32'(ff_leak), 32'd0);

        // all busy: fifth record must wait
        push_record();
        repeat (300) step();
        check_eq("t4_no_start", 32'(n_starts), 32'd4);
        check_eq("t4_not_idle", 32'(idle), 32'd0);

        // cores 1 and 3 ready together with cptr at 0; sink full pulsed
        hold_res = 4'b0101;
        rnd_sink = 1;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (n_collected >= 2 && n_starts == 5) begin ok = 1; break; end
        end
        check_eq("t3_done", 32'(ok), 32'd1);
        check_eq("t3_first", (col_order.size() > 0) ? 32'(col_order[0]) : 32'hFFFF_FFFF, 32'd1);
        check_eq("t3_second", (col_order.size() > 1) ? 32'(col_order[1]) : 32'hFFFF_FFFF, 32'd3);
        check_eq("t4_freed_core", (start_order.size() > 4) ? 32'(start_order[4]) : 32'hFFFF_FFFF, 32'd1);

        // release everything with random stalls and drain
        hold_res = '0;
        rnd_src = 1; rnd_full = 1; rnd_res = 1;
        ok = 0;
        for (int i = 0; i < 8000; i++) begin
            step();
            if (n_collected == 5) begin ok = 1; break; end
        end
        check_eq("drain_done", 32'(ok), 32'd1);
        repeat (3) step();
        check_eq("drain_idle", 32'(idle), 32'd1);

        // enable dropped at word 100: record completes, then nothing starts
        for (int r = 0; r < 6; r++) push_record();
        drop_at100 = 1;
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (!enable && !drop_at100 && busy_m == '0) begin ok = 1; break; end
        end
        check_eq("t5_drain", 32'(ok), 32'd1);
        saved = n_starts;
        repeat (50) step();
        check_eq("t5_no_start", 32'(n_starts), 32'(saved));
        check_eq("t5_record_words", (cur_core >= 0) ? 32'(rx_cnt[cur_core]) : 32'd0, 32'(RL));
        check_eq("t5_idle", 32'(idle), 32'd1);
        enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 40000; i++) begin
            step();
            if (srcq.size() == 0 && busy_m == '0 && rx_cnt[cur_core] == RL) begin ok = 1; break; end
        end
        check_eq("t5_rest_done", 32'(ok), 32'd1);
        repeat (3) step();
        check_eq("t5_final_idle", 32'(idle), 32'd1);
`ifdef DTW_DISPATCH_STATS_EN
        check_eq("stat_dispatched", stat_dispatched, 32'(n_starts));
        check_eq("stat_collected", stat_collected, 32'(n_collected));
`endif

        // reset in the middle of streaming
        for (int r = 0; r < 2; r++) push_record();
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (cur_core >= 0 && rx_cnt[cur_core] == 30) begin ok = 1; break; end
        end
        check_eq("t6_streaming", 32'(ok), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_strobes", 32'({core_start, core_wr_en, core_rd_en, src_fifo_rden, sink_fifo_wren}), 32'd0);
        check_eq("t6_idle", 32'(idle), 32'd1);
`ifdef DTW_DISPATCH_STATS_EN
        check_eq("t6_stats", stat_dispatched | stat_collected, 32'd0);
`endif
        clear_model();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        check_eq("t6_idle_after", 32'(idle), 32'd1);
        check_eq("t6_no_start", 32'(n_starts), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
